div3_fixup: RTL and testbench

DIV3_FIXUP -- requirements
Module: div3_fixup

---
 rtl/div3_fixup.sv | 189 ++++++++++++++++++
 tb/tb_div3_fixup.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div3_fixup.sv
// rtl/div3_fixup.sv - corrects approximate divide-by-3 quotients against buffered dividends
module div3_fixup #(
    parameter int DWIDTH     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DWIDTH-1:0]             i_n,
    input  logic                          i_n_valid,
    input  logic [DWIDTH-1:0]             i_q,
    input  logic                          i_q_valid,
    output logic [DWIDTH-1:0]             o_q,
    output logic [1:0]                    o_r,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic [3:0]                    o_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DWIDTH + 3;
    localparam logic [AW:0]          LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic signed [EW-1:0] E_N6 = EW'(-6);
    localparam logic signed [EW-1:0] E_N3 = EW'(-3);
    localparam logic signed [EW-1:0] E_P3 = EW'(3);
    localparam logic signed [EW-1:0] E_P6 = EW'(6);
    localparam logic signed [EW-1:0] E_P8 = EW'(8);

    // dividend FIFO
    logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;

    // stage 1: popped dividend paired with its approximate quotient
    logic              r_s1_valid;
    logic [DWIDTH-1:0] r_s1_n;
    logic [DWIDTH-1:0] r_s1_q;

    // stage 2: residual and correction
    logic signed [EW-1:0] w_e;
    logic [DWIDTH-1:0]    w_cq;
    logic [1:0]           w_cr;
    logic                 w_range_err;

    // two-entry output buffer, entry 0 is the head
    logic [DWIDTH-1:0] r_b0_q;
    logic [DWIDTH-1:0] r_b1_q;
    logic [1:0]        r_b0_r;
    logic [1:0]        r_b1_r;
    logic [1:0]        r_bcnt;
    logic              w_out_pop;
    logic              w_buf_acc;
    logic              w_wr_hi;

    logic [3:0]        r_err;

    assign w_fifo_full  = (r_level == LVL_FULL);
    assign w_fifo_empty = (r_level == '0);
    assign w_push       = i_n_valid && !w_fifo_full;
    // pop decision uses the pre-push level, so a same-cycle push cannot be popped
    assign w_pop        = i_q_valid && !w_fifo_empty;

    // dividend storage, no reset needed since occupancy is tracked by pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_n;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // stage 1 register captures the FIFO head together with the incoming quotient
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_n     <= '0;
            r_s1_q     <= '0;
        end else begin
            r_s1_valid <= w_pop;
            if (w_pop) begin
                r_s1_n <= r_mem[r_rd_ptr];
                r_s1_q <= i_q;
            end
        end
    end

    // residual e = n - 3q, wide enough that no operand combination truncates
    assign w_e = signed'({3'b000, r_s1_n})
               - signed'({2'b00, r_s1_q, 1'b0})
               - signed'({3'b000, r_s1_q});

    // pick a quotient adjustment of -2..+2; remainder only needs low two bits of e - 3k
    always_comb begin
        w_range_err = 1'b0;
        w_cq        = r_s1_q;
        w_cr        = 2'd0;
        if (w_e < E_N6 || w_e > E_P8) begin
            w_range_err = 1'b1;
        end else if (w_e < E_N3) begin
            w_cq = r_s1_q - DWIDTH'(2);
            w_cr = w_e[1:0] + 2'd2;
        end else if (w_e[EW-1]) begin
            w_cq = r_s1_q - DWIDTH'(1);
            w_cr = w_e[1:0] + 2'd3;
        end else if (w_e < E_P3) begin
            w_cr = w_e[1:0];
        end else if (w_e < E_P6) begin
            w_cq = r_s1_q + DWIDTH'(1);
            w_cr = w_e[1:0] + 2'd1;
        end else begin
            w_cq = r_s1_q + DWIDTH'(2);
            w_cr = w_e[1:0] + 2'd2;
        end
    end

    assign w_out_pop = (r_bcnt != 2'd0) && i_ready;
    // a full buffer still accepts when its head leaves in the same cycle
    assign w_buf_acc = r_s1_valid && ((r_bcnt != 2'd2) || w_out_pop);
    assign w_wr_hi   = ((r_bcnt - {1'b0, w_out_pop}) == 2'd1);

    // output buffer: shift on pop, then write at the first free slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b0_q <= '0;
            r_b0_r <= '0;
            r_b1_q <= '0;
            r_b1_r <= '0;
            r_bcnt <= '0;
        end else begin
            if (w_out_pop) begin
                r_b0_q <= r_b1_q;
                r_b0_r <= r_b1_r;
            end
            if (w_buf_acc) begin
                if (w_wr_hi) begin
                    r_b1_q <= w_cq;
                    r_b1_r <= w_cr;
                end else begin
                    r_b0_q <= w_cq;
                    r_b0_r <= w_cr;
                end
            end
            r_bcnt <= r_bcnt + {1'b0, w_buf_acc} - {1'b0, w_out_pop};
        end
    end

    // sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | {r_s1_valid && w_range_err,
                              r_s1_valid && !w_buf_acc,
                              i_q_valid && w_fifo_empty,
                              i_n_valid && w_fifo_full};
        end
    end

    assign o_valid = (r_bcnt != 2'd0);
    assign o_q     = r_b0_q;
    assign o_r     = r_b0_r;
    assign o_level = r_level;
    assign o_err   = r_err;

endmodule

// File: tb/tb_div3_fixup.sv
// tb/tb_div3_fixup.sv - self-checking bench for div3_fixup
module tb_div3_fixup;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic           clk;
    logic           rst;
    logic [DW-1:0]  i_n;
    logic           i_n_valid;
    logic [DW-1:0]  i_q;
    logic           i_q_valid;
    logic [DW-1:0]  o_q;
    logic [1:0]     o_r;
    logic           o_valid;
    logic           i_ready;
    logic [3:0]     o_level;
    logic [3:0]     o_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int q;
        int r;
    } res_t;

    int         nq[$];
    res_t       bq[$];
    bit         s1_v;
    int         s1_n;
    int         s1_q;
    logic [3:0] m_err;

    div3_fixup #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_n       (i_n),
        .i_n_valid (i_n_valid),
        .i_q       (i_q),
        .i_q_valid (i_q_valid),
        .o_q       (o_q),
        .o_r       (o_r),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_level   (o_level),
        .o_err     (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the true floor division holds whenever the approximation is within the fixable window
    function automatic void expect_res(input int n, input int q,
                                       output int eq, output int er, output bit bad);
        int e;
        e = n - 3 * q;
        if (e >= -6 && e <= 8) begin
            eq  = n / 3;
            er  = n % 3;
            bad = 1'b0;
        end else begin
            eq  = q;
            er  = 0;
            bad = 1'b1;
        end
    endfunction

    function automatic void model_clear();
        nq.delete();
        bq.delete();
        s1_v  = 1'b0;
        s1_n  = 0;
        s1_q  = 0;
        m_err = 4'b0000;
    endfunction

    // one clock: compare visible outputs to the model, drive inputs, advance the model
    task automatic step(input bit nv, input int n, input bit qv, input int q, input bit rdy);
        int   old_sz;
        bit   popo;
        bit   acc;
        bit   bad;
        int   eq;
        int   er;
        res_t t;
        bit   ns_v;
        int   ns_n;
        int   ns_q;

        checks++;
        if (o_valid !== (bq.size() > 0)) begin
            failures++;
            $display("FAIL step_valid t=%0t got=%0b want=%0b", $time, o_valid, bq.size() > 0);
        end
        if (bq.size() > 0) begin
            checks++;
            if (o_q !== DW'(bq[0].q) || o_r !== 2'(bq[0].r)) begin
                failures++;
                $display("FAIL step_data t=%0t got q=%0d r=%0d want q=%0d r=%0d",
                         $time, o_q, o_r, bq[0].q, bq[0].r);
            end
        end
        checks++;
        if (o_level !== 4'(nq.size())) begin
            failures++;
            $display("FAIL step_level t=%0t got=%0d want=%0d", $time, o_level, nq.size());
        end
        checks++;
        if (o_err !== m_err) begin
            failures++;
            $display("FAIL step_err t=%0t got=%b want=%b", $time, o_err, m_err);
        end

        i_n_valid = nv;
        i_n       = DW'(n);
        i_q_valid = qv;
        i_q       = DW'(q);
        i_ready   = rdy;

        old_sz = nq.size();
        popo   = (bq.size() > 0) && rdy;
        acc    = 1'b0;
        if (s1_v) begin
            expect_res(s1_n, s1_q, eq, er, bad);
            if (bad) m_err[3] = 1'b1;
            if (bq.size() < 2 || popo) acc = 1'b1;
            else m_err[2] = 1'b1;
        end
        if (popo) void'(bq.pop_front());
        if (acc) begin
            t.q = eq;
            t.r = er;
            bq.push_back(t);
        end
        ns_v = 1'b0;
        ns_n = 0;
        ns_q = 0;
        if (qv) begin
            if (old_sz > 0) begin
                ns_n = nq.pop_front();
                ns_q = q;
                ns_v = 1'b1;
            end else begin
                m_err[1] = 1'b1;
            end
        end
        if (nv) begin
            if (old_sz < DEPTH) nq.push_back(n);
            else m_err[0] = 1'b1;
        end
        s1_v = ns_v;
        s1_n = ns_n;
        s1_q = ns_q;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_n_valid = 1'b0;
        i_q_valid = 1'b0;
        i_ready   = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_q !== '0 || o_r !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b q=%0d r=%0d want 0 0 0", o_valid, o_q, o_r);
        end
        checks++;
        if (o_level !== 4'd0 || o_err !== 4'd0) begin
            failures++;
            $display("FAIL reset_status got level=%0d err=%b want 0 0000", o_level, o_err);
        end
        rst = 1'b0;
        model_clear();
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_basic();
        do_reset();
        step(1, 200, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 66, 1);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early got valid=%0b want 0", o_valid);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_valid !== 1'b1 || o_q !== 8'd66 || o_r !== 2'd2) begin
            failures++;
            $display("FAIL basic_result got v=%0b q=%0d r=%0d want 1 66 2", o_valid, o_q, o_r);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_corrections();
        int cn[4];
        int cq[4];
        int xq[4];
        int xr[4];
        cn = '{7, 9, 255, 0};
        cq = '{3, 2, 83, 5};
        xq = '{2, 3, 85, 5};
        xr = '{1, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, cn[i], 0, 0, 1);
            step(0, 0, 1, cq[i], 1);
            step(0, 0, 0, 0, 1);
            checks++;
            if (o_valid !== 1'b1 || o_q !== DW'(xq[i]) || o_r !== 2'(xr[i])) begin
                failures++;
                $display("FAIL corr_%0d got v=%0b q=%0d r=%0d want 1 %0d %0d",
                         i, o_valid, o_q, o_r, xq[i], xr[i]);
            end
            step(0, 0, 0, 0, 1);
        end
        checks++;
        if (o_err[3] !== 1'b1) begin
            failures++;
            $display("FAIL corr_range_err got=%0b want 1", o_err[3]);
        end
    endtask

    task automatic test_overflow();
        int vals[9];
        do_reset();
        for (int i = 0; i < 9; i++) begin
            vals[i] = int'($urandom_range(0, 255));
            step(1, vals[i], 0, 0, 1);
        end
        checks++;
        if (o_level !== 4'd8 || o_err[0] !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full got level=%0d err0=%0b want 8 1", o_level, o_err[0]);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, vals[i] / 3, 1);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        checks++;
        if (o_level !== 4'd0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain got level=%0d valid=%0b want 0 0", o_level, o_valid);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(0, 0, 1, 17, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_err[1] !== 1'b1 || o_valid !== 1'b0 || o_level !== 4'd0) begin
            failures++;
            $display("FAIL underflow got err1=%0b valid=%0b level=%0d want 1 0 0",
                     o_err[1], o_valid, o_level);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, 30, 0, 0, 0);
        step(1, 31, 0, 0, 0);
        step(1, 32, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 10, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_q !== 8'd10 || o_r !== 2'd0 || o_err[2] !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold got v=%0b q=%0d r=%0d err2=%0b want 1 10 0 1",
                     o_valid, o_q, o_r, o_err[2]);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_valid !== 1'b1 || o_q !== 8'd10 || o_r !== 2'd1) begin
            failures++;
            $display("FAIL bp_second got v=%0b q=%0d r=%0d want 1 10 1", o_valid, o_q, o_r);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty got valid=%0b want 0", o_valid);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_midop();
        do_reset();
        step(1, 10, 0, 0, 0);
        step(1, 20, 0, 0, 0);
        step(1, 30, 0, 0, 0);
        step(1, 40, 1, 3, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_level !== 4'd3) begin
            failures++;
            $display("FAIL midrst_setup got valid=%0b level=%0d want 1 3", o_valid, o_level);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_q !== '0 || o_r !== 2'd0 || o_level !== 4'd0 || o_err !== 4'd0) begin
            failures++;
            $display("FAIL midrst_async got v=%0b q=%0d r=%0d level=%0d err=%b want all 0",
                     o_valid, o_q, o_r, o_level, o_err);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after got valid=%0b want 0", o_valid);
        end
        step(1, 12, 0, 0, 1);
        step(0, 0, 1, 4, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_valid !== 1'b1 || o_q !== 8'd4 || o_r !== 2'd0) begin
            failures++;
            $display("FAIL midrst_new got v=%0b q=%0d r=%0d want 1 4 0", o_valid, o_q, o_r);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        bit nv;
        bit qv;
        bit rdy;
        int n;
        int q;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            nv  = ($urandom_range(0, 2) != 0);
            qv  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            n   = int'($urandom_range(0, 255));
            if (nq.size() > 0 && $urandom_range(0, 15) != 0) begin
                q = nq[0] / 3 + int'($urandom_range(0, 4)) - 2;
                if (q < 0) q = 0;
                if (q > 255) q = 255;
            end else begin
                q = int'($urandom_range(0, 255));
            end
            step(nv, n, qv, q, rdy);
        end
        for (int c = 0; c < 6; c++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        i_n       = '0;
        i_n_valid = 1'b0;
        i_q       = '0;
        i_q_valid = 1'b0;
        i_ready   = 1'b1;
        model_clear();
        test_reset();
        test_basic();
        test_corrections();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
